qbert_jump_ctrl: RTL and testbench

QBERT_JUMP_CTRL -- requirements
Module: qbert_jump_ctrl

---
 rtl/qbert_jump_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_qbert_jump_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_jump_ctrl.sv
// Q*bert hop controller: debounced diagonal buttons start timed JUMP/LAND/FALL
// sequences and track the current cube on a 7-row pyramid.
module qbert_jump_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] JUMP_CYCLES     = 32'd1000000,
  parameter logic [31:0] LAND_CYCLES     = 32'd250000,
  parameter logic [31:0] FALL_CYCLES     = 32'd4000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_en,
  input  logic [3:0] btn,
  output logic [3:0] qbert_jump,
  output logic [2:0] cube_row,
  output logic [2:0] cube_col,
  output logic       cube_visit,
  output logic       fell,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, JUMP, LAND, FALL} state_e;

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  deb_q, deb_d, deb_prev_q;
  logic [15:0] db_cnt_q [4];
  logic [15:0] db_cnt_d [4];
  logic [3:0]  rise;
  logic        press_vld;

  logic        pend_v_q, pend_v_d;
  logic [3:0]  pend_dir_q, pend_dir_d;

  state_e      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [3:0]  dir_q, dir_d;
  logic [3:0]  jump_q, jump_d;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic        visit_q, visit_d, fell_q, fell_d;
  logic        consume, fall_done;

  logic signed [3:0] d_row, d_col, tgt_row, tgt_col;
  logic              tgt_ok;

  // NOTE: a level is accepted only after differing for DEBOUNCE_CYCLES straight cycles;
  // every variable driven here gets its default before any branch so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) deb_d[i] = sync2_q[i];
        else                                        db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  assign rise      = deb_q & ~deb_prev_q;
  assign press_vld = $onehot(rise);

  // NOTE: the debounce counters are a handful of flops, so they are reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // A fresh single-button press always replaces an older unconsumed one.
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    if (!game_en || fall_done) begin
      pend_v_d = 1'b0;
    end else if (press_vld) begin
      pend_v_d   = 1'b1;
      pend_dir_d = rise;
    end else if (consume) begin
      pend_v_d = 1'b0;
    end
  end

  // Signed 4-bit target so stepping up/left from row or column 0 goes negative.
  always_comb begin
    d_row   = (dir_q[0] | dir_q[1]) ? 4'sd1 : -4'sd1;
    d_col   = dir_q[0] ? 4'sd1 : (dir_q[3] ? -4'sd1 : 4'sd0);
    tgt_row = $signed({1'b0, row_q}) + d_row;
    tgt_col = $signed({1'b0, col_q}) + d_col;
    tgt_ok  = (tgt_row >= 4'sd0) && (tgt_row <= 4'sd6) &&
              (tgt_col >= 4'sd0) && (tgt_col <= tgt_row);
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 32'd1;
    dir_d     = dir_q;
    jump_d    = jump_q;
    row_d     = row_q;
    col_d     = col_q;
    visit_d   = 1'b0;
    fell_d    = 1'b0;
    consume   = 1'b0;
    fall_done = 1'b0;
    if (!game_en) begin
      state_d = IDLE;
      phase_d = '0;
      jump_d  = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d = '0;
          if (pend_v_q) begin
            consume = 1'b1;
            dir_d   = pend_dir_q;
            jump_d  = pend_dir_q;
            state_d = JUMP;
          end
        end
        JUMP: begin
          if (phase_q == JUMP_CYCLES - 32'd1) begin
            phase_d = '0;
            if (tgt_ok) begin
              row_d   = tgt_row[2:0];
              col_d   = tgt_col[2:0];
              visit_d = 1'b1;
              jump_d  = '0;
              state_d = LAND;
            end else begin
              state_d = FALL;
            end
          end
        end
        LAND: begin
          if (phase_q == LAND_CYCLES - 32'd1) begin
            phase_d = '0;
            state_d = IDLE;
          end
        end
        FALL: begin
          if (phase_q == FALL_CYCLES - 32'd1) begin
            phase_d   = '0;
            row_d     = '0;
            col_d     = '0;
            jump_d    = '0;
            fell_d    = 1'b1;
            fall_done = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          phase_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      dir_q      <= '0;
      jump_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      visit_q    <= 1'b0;
      fell_q     <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_dir_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      jump_q     <= jump_d;
      row_q      <= row_d;
      col_q      <= col_d;
      visit_q    <= visit_d;
      fell_q     <= fell_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign qbert_jump = jump_q;
  assign cube_row   = row_q;
  assign cube_col   = col_q;
  assign cube_visit = visit_q;
  assign fell       = fell_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Self-checking bench for qbert_jump_ctrl: directed hop scenarios with spec-derived
// timing, then random buttons against a cycle-level behavioural model.
module tb_qbert_jump_ctrl;

  localparam int DB  = 4;
  localparam int JC  = 8;
  localparam int LC  = 3;
  localparam int FC  = 5;
  // Press to first jump cycle: 2 sync stages, DB stable cycles, edge detect, pending consume.
  localparam int LAT = DB + 4;

  localparam logic [3:0] DR = 4'b0001;
  localparam logic [3:0] DL = 4'b0010;
  localparam logic [3:0] UR = 4'b0100;
  localparam logic [3:0] UL = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_en;
  logic [3:0] btn;
  logic [3:0] qbert_jump;
  logic [2:0] cube_row, cube_col;
  logic       cube_visit, fell, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qbert_jump_ctrl #(
    .DEBOUNCE_CYCLES(16'(DB)),
    .JUMP_CYCLES    (32'(JC)),
    .LAND_CYCLES    (32'(LC)),
    .FALL_CYCLES    (32'(FC))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .game_en   (game_en),
    .btn       (btn),
    .qbert_jump(qbert_jump),
    .cube_row  (cube_row),
    .cube_col  (cube_col),
    .cube_visit(cube_visit),
    .fell      (fell),
    .busy      (busy)
  );

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_JUMP, M_LAND, M_FALL} mmode_e;

  logic [3:0] m_hist [0:DB+1];
  logic [3:0] m_deb, m_rise, m_dir, m_jump, m_pend_dir;
  logic       m_pend_v, m_visit, m_fell;
  int         m_row, m_col, m_remain;
  mmode_e     m_mode;

  task automatic model_reset();
    for (int i = 0; i <= DB + 1; i++) m_hist[i] = '0;
    m_deb = '0; m_rise = '0; m_dir = '0; m_jump = '0; m_pend_dir = '0;
    m_pend_v = 1'b0; m_visit = 1'b0; m_fell = 1'b0;
    m_row = 0; m_col = 0; m_remain = 0; m_mode = M_IDLE;
  endtask

  task automatic model_step();
    logic [3:0] press;
    logic       flip, consumed, fall_done;
    int         tr, tc;
    press = m_rise;
    for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = btn;
    m_rise = '0;
    // A bit flips once the last DB synchronised samples all disagree with it.
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (m_hist[i][b] == m_deb[b]) flip = 1'b0;
      if (flip) begin
        m_rise[b] = ~m_deb[b];
        m_deb[b]  = ~m_deb[b];
      end
    end
    m_visit = 1'b0;
    m_fell  = 1'b0;
    if (!game_en) begin
      m_mode = M_IDLE; m_row = 0; m_col = 0; m_jump = '0; m_pend_v = 1'b0;
    end else begin
      consumed  = 1'b0;
      fall_done = 1'b0;
      case (m_mode)
        M_IDLE: if (m_pend_v) begin
          m_mode = M_JUMP; m_dir = m_pend_dir; m_jump = m_pend_dir;
          m_remain = JC; consumed = 1'b1;
        end
        M_JUMP: begin
          m_remain--;
          if (m_remain == 0) begin
            tr = m_row + ((m_dir[0] | m_dir[1]) ? 1 : -1);
            tc = m_col + (m_dir[0] ? 1 : (m_dir[3] ? -1 : 0));
            if (tr >= 0 && tr <= 6 && tc >= 0 && tc <= tr) begin
              m_row = tr; m_col = tc; m_visit = 1'b1; m_jump = '0;
              m_mode = M_LAND; m_remain = LC;
            end else begin
              m_mode = M_FALL; m_remain = FC;
            end
          end
        end
        M_LAND: begin
          m_remain--;
          if (m_remain == 0) m_mode = M_IDLE;
        end
        M_FALL: begin
          m_remain--;
          if (m_remain == 0) begin
            m_row = 0; m_col = 0; m_jump = '0; m_fell = 1'b1;
            m_mode = M_IDLE; fall_done = 1'b1;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      if (fall_done)                     m_pend_v = 1'b0;
      else if ($countones(press) == 1) begin m_pend_v = 1'b1; m_pend_dir = press; end
      else if (consumed)                 m_pend_v = 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------- directed scenarios ----------------
  // Presses dir for `hold` cycles and follows the resulting hop for 45 cycles.
  task automatic run_hop(input logic [3:0] dir, input int hold, input int er, input int ec,
                         input bit exp_fall, input string tag);
    int t_start = -1, t_visit = -1, t_fell = -1, t_idle = -1;
    int jcnt = 0, bad_jump = 0, nvisit = 0, nfell = 0, both = 0;
    btn = dir;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (qbert_jump != 4'b0 && t_start < 0) t_start = c;
      if (qbert_jump == dir) jcnt++;
      else if (qbert_jump != 4'b0) bad_jump++;
      if (cube_visit) begin nvisit++; t_visit = c; end
      if (fell) begin nfell++; t_fell = c; end
      if (cube_visit && fell) both++;
      if (t_start > 0 && !busy && t_idle < 0) t_idle = c;
      if (c == hold) btn = 4'b0;
    end
    n_assert++; if (t_start !== LAT) begin n_fail++; $display("FAIL %s start_latency: got %0d want %0d", tag, t_start, LAT); end
    n_assert++; if (both !== 0) begin n_fail++; $display("FAIL %s visit_and_fell: got %0d want 0", tag, both); end
    n_assert++; if (bad_jump !== 0) begin n_fail++; $display("FAIL %s wrong_dir_cycles: got %0d want 0", tag, bad_jump); end
    n_assert++;
    if ({cube_row, cube_col} !== {3'(er), 3'(ec)}) begin
      n_fail++; $display("FAIL %s position: got (%0d,%0d) want (%0d,%0d)", tag, cube_row, cube_col, er, ec);
    end
    if (!exp_fall) begin
      n_assert++; if (jcnt !== JC) begin n_fail++; $display("FAIL %s jump_cycles: got %0d want %0d", tag, jcnt, JC); end
      n_assert++; if (nvisit !== 1 || nfell !== 0) begin n_fail++; $display("FAIL %s pulses: got visit=%0d fell=%0d want 1/0", tag, nvisit, nfell); end
      n_assert++; if (t_visit !== t_start + JC) begin n_fail++; $display("FAIL %s visit_time: got %0d want %0d", tag, t_visit, t_start + JC); end
      n_assert++; if (t_idle !== t_visit + LC) begin n_fail++; $display("FAIL %s idle_time: got %0d want %0d", tag, t_idle, t_visit + LC); end
    end else begin
      n_assert++; if (jcnt !== JC + FC) begin n_fail++; $display("FAIL %s jump_cycles: got %0d want %0d", tag, jcnt, JC + FC); end
      n_assert++; if (nfell !== 1 || nvisit !== 0) begin n_fail++; $display("FAIL %s pulses: got visit=%0d fell=%0d want 0/1", tag, nvisit, nfell); end
      n_assert++; if (t_fell !== t_start + JC + FC) begin n_fail++; $display("FAIL %s fell_time: got %0d want %0d", tag, t_fell, t_start + JC + FC); end
      n_assert++; if (t_idle !== t_fell) begin n_fail++; $display("FAIL %s idle_time: got %0d want %0d", tag, t_idle, t_fell); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; game_en = 1'b1; btn = 4'b0;
    repeat (3) @(negedge clk);
    n_assert++; if (qbert_jump !== 4'b0) begin n_fail++; $display("FAIL reset jump: got %b want 0000", qbert_jump); end
    n_assert++; if (cube_row !== 3'd0) begin n_fail++; $display("FAIL reset row: got %0d want 0", cube_row); end
    n_assert++; if (cube_col !== 3'd0) begin n_fail++; $display("FAIL reset col: got %0d want 0", cube_col); end
    n_assert++; if (cube_visit !== 1'b0) begin n_fail++; $display("FAIL reset visit: got %b want 0", cube_visit); end
    n_assert++; if (fell !== 1'b0) begin n_fail++; $display("FAIL reset fell: got %b want 0", fell); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hop();
    run_hop(DR, 10, 1, 1, 1'b0, "dr_first");
  endtask

  task automatic test_fall_top();
    run_hop(UL, 10, 0, 0, 1'b0, "ul_to_top");
    run_hop(UR, 10, 0, 0, 1'b1, "ur_off_top");
  endtask

  task automatic test_glitch();
    int stray = 0;
    btn = DR;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (qbert_jump != 4'b0 || busy) stray++;
      if (c == DB - 1) btn = 4'b0;
    end
    n_assert++; if (stray !== 0) begin n_fail++; $display("FAIL glitch: got %0d active cycles want 0", stray); end
    run_hop(DR, DB, 1, 1, 1'b0, "min_hold");
  endtask

  task automatic test_multi_press();
    int stray = 0;
    btn = DR | DL;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (qbert_jump != 4'b0 || busy) stray++;
      if (c == 10) btn = 4'b0;
    end
    n_assert++; if (stray !== 0) begin n_fail++; $display("FAIL multi_press: got %0d active cycles want 0", stray); end
    run_hop(DL, 10, 2, 1, 1'b0, "after_multi");
  endtask

  task automatic test_back_to_back();
    logic [3:0] starts [$];
    int         start_t [$];
    logic [3:0] prev_j = 4'b0;
    int         t_visit1 = -1;
    btn = UR;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (qbert_jump != 4'b0 && prev_j == 4'b0) begin starts.push_back(qbert_jump); start_t.push_back(c); end
      if (cube_visit && t_visit1 < 0) t_visit1 = c;
      prev_j = qbert_jump;
      if (c == 8)  btn = DL;
      if (c == 11) btn = DL | DR;
      if (c == 16) btn = 4'b0;
    end
    n_assert++; if (starts.size() !== 2) begin n_fail++; $display("FAIL b2b hop_count: got %0d want 2", starts.size()); end
    if (starts.size() >= 2) begin
      n_assert++; if (starts[0] !== UR) begin n_fail++; $display("FAIL b2b first_dir: got %b want %b", starts[0], UR); end
      n_assert++; if (starts[1] !== DR) begin n_fail++; $display("FAIL b2b second_dir: got %b want %b", starts[1], DR); end
      n_assert++; if (start_t[1] !== t_visit1 + LC + 1) begin n_fail++; $display("FAIL b2b second_start: got %0d want %0d", start_t[1], t_visit1 + LC + 1); end
    end
    n_assert++; if ({cube_row, cube_col} !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL b2b position: got (%0d,%0d) want (2,2)", cube_row, cube_col); end
  endtask

  task automatic test_walk_edge();
    @(negedge clk); game_en = 1'b0;
    @(negedge clk);
    n_assert++; if ({cube_row, cube_col, busy} !== 7'd0) begin n_fail++; $display("FAIL en_low_idle: got row=%0d col=%0d busy=%b want 0", cube_row, cube_col, busy); end
    game_en = 1'b1;
    @(negedge clk);
    run_hop(DL, 10, 1, 0, 1'b0, "walk_1");
    run_hop(UL, 10, 0, 0, 1'b1, "col_underflow");
    for (int k = 1; k <= 6; k++) run_hop(DL, 10, k, 0, 1'b0, $sformatf("walk_%0d", k));
    run_hop(DL, 10, 0, 0, 1'b1, "off_bottom");
  endtask

  task automatic test_game_en_mid();
    int stray = 0;
    run_hop(DR, 10, 1, 1, 1'b0, "en_setup");
    btn = DR;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 4)  btn = DR | DL;
      if (c == 10) btn = 4'b0;
      if (c == 12) begin
        n_assert++; if (qbert_jump !== DR) begin n_fail++; $display("FAIL en_mid pre_drop: got %b want %b", qbert_jump, DR); end
        game_en = 1'b0;
      end
      if (c == 13) begin
        n_assert++;
        if ({qbert_jump, cube_row, cube_col, busy, cube_visit, fell} !== 13'd0) begin
          n_fail++; $display("FAIL en_mid forced: got jump=%b row=%0d col=%0d busy=%b visit=%b fell=%b want all 0",
                             qbert_jump, cube_row, cube_col, busy, cube_visit, fell);
        end
        game_en = 1'b1;
      end
      if (c > 13 && (qbert_jump != 4'b0 || busy)) stray++;
    end
    n_assert++; if (stray !== 0) begin n_fail++; $display("FAIL en_mid pending_kept: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] dirs [2];
    int         at [2];
    dirs[0] = DR; at[0] = 11;
    dirs[1] = UR; at[1] = 18;
    for (int s = 0; s < 2; s++) begin
      int stray = 0;
      btn = dirs[s];
      for (int c = 1; c <= at[s]; c++) begin
        @(negedge clk);
        if (c == 10) btn = 4'b0;
      end
      n_assert++; if (qbert_jump !== dirs[s] || !busy) begin n_fail++; $display("FAIL rst_mid_%0d pre: got jump=%b busy=%b want %b/1", s, qbert_jump, busy, dirs[s]); end
      #2 reset = 1'b0;
      #1;
      n_assert++;
      if ({qbert_jump, cube_row, cube_col, cube_visit, fell, busy} !== 13'd0) begin
        n_fail++; $display("FAIL rst_mid_%0d async: got jump=%b row=%0d col=%0d visit=%b fell=%b busy=%b want all 0",
                           s, qbert_jump, cube_row, cube_col, cube_visit, fell, busy);
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (qbert_jump != 4'b0 || cube_visit || fell || busy || cube_row != 3'd0 || cube_col != 3'd0) stray++;
      end
      n_assert++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_%0d after: got %0d active cycles want 0", s, stray); end
    end
  endtask

  task automatic test_random();
    int         hold = 0, off = 0, errs = 0;
    logic [13:0] got, exp_v;
    @(negedge clk); reset = 1'b0; btn = 4'b0; game_en = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 4000 && errs < 20; c++) begin
      @(negedge clk);
      got   = {qbert_jump, cube_row, cube_col, cube_visit, fell, busy};
      exp_v = {m_jump, 3'(m_row), 3'(m_col), m_visit, m_fell, (m_mode != M_IDLE)};
      n_assert++;
      if (got !== exp_v) begin
        n_fail++; errs++;
        $display("FAIL random cycle %0d: got %b want %b (jump,row,col,visit,fell,busy)", c, got, exp_v);
      end
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    btn = 4'b0;
          2:       btn = 4'($urandom);
          default: btn = 4'b1 << $urandom_range(0, 3);
        endcase
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      if (off > 0) begin
        off--;
        if (off == 0) game_en = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        game_en = 1'b0;
        off = $urandom_range(1, 3);
      end
    end
    btn = 4'b0; game_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_hop();
    test_fall_top();
    test_glitch();
    test_multi_press();
    test_back_to_back();
    test_walk_edge();
    test_game_en_mid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
